// File: rtl/uart_pkg.sv
// Shared types and format encodings for the framed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] DB_5 = 2'd0;
  localparam logic [1:0] DB_6 = 2'd1;
  localparam logic [1:0] DB_7 = 2'd2;
  localparam logic [1:0] DB_8 = 2'd3;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] STOP_1   = 2'd0;
  localparam logic [1:0] STOP_1P5 = 2'd1;
  localparam logic [1:0] STOP_2   = 2'd2;

  typedef struct packed {
    logic [1:0] data_bits;
    logic [1:0] par_sel;
    logic [1:0] stop_sel;
  } frame_cfg_t;

  function automatic logic parity_enabled(input logic [1:0] par_sel);
    return (par_sel == PAR_EVEN) || (par_sel == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable frame format, baud divisor and input FIFO.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_W-1:0]              comp,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    par_sel,
  input  logic [1:0]                    stop_sel,
  input  logic                          tr_en,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_tx
);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, comp_q, comp_d, bit_lim;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d, mask, fifo_dout;
  logic             par_q, par_d;
  frame_cfg_t       cfg_q, cfg_d;
  logic             pop, full, empty, stop_end, bit_end, line_d;
  logic             uart_tx_q, done_pend_q, tx_done_q;
  logic [DIV_W:0]   half_m1;

  assign tx_ready = tr_en && !full;
  assign busy     = (state_q != ST_IDLE) || !empty;
  assign uart_tx  = uart_tx_q;
  assign tx_done  = tx_done_q;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_valid && tx_ready),
    .pop    (pop),
    .flush  (!tr_en),
    .din    (tx_data),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  // Half stop bit ends at (T>>1)-1 with T = comp+1.
  assign half_m1 = ((({1'b0, comp_q}) + (DIV_W+1)'(1)) >> 1) - (DIV_W+1)'(1);
  assign bit_lim = (state_q == ST_STOP && cfg_q.stop_sel == STOP_1P5 && idx_q == 3'd1)
                   ? half_m1[DIV_W-1:0] : comp_q;
  assign bit_end = (cnt_q == bit_lim);
  assign mask    = 8'hFF >> (2'd3 - data_bits);

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    comp_d   = comp_q;
    cfg_d    = cfg_q;
    par_d    = par_q;
    pop      = 1'b0;
    stop_end = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == {1'b0, cfg_q.data_bits} + 3'd4) begin
            idx_d = '0;
            if (parity_enabled(cfg_q.par_sel)) begin
              state_d = ST_PARITY;
              shift_d = {7'b0, par_q};
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if ((cfg_q.stop_sel == STOP_1) ? (idx_q == 3'd0) : (idx_q == 3'd1)) begin
            stop_end = 1'b1;
            state_d  = empty ? ST_IDLE : ST_START;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any entry into START (from IDLE or straight out of STOP) takes a word and the format.
    if (state_d == ST_START && state_q != ST_START) begin
      pop     = 1'b1;
      cnt_d   = '0;
      idx_d   = '0;
      comp_d  = comp;
      cfg_d   = '{data_bits: data_bits, par_sel: par_sel, stop_sel: stop_sel};
      shift_d = fifo_dout & mask;
      par_d   = (^(fifo_dout & mask)) ^ (par_sel == PAR_ODD);
    end

    if (!tr_en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      pop      = 1'b0;
      stop_end = 1'b0;
    end
  end

  always_comb begin
    line_d = 1'b1;
    unique case (state_q)
      ST_START:            line_d = 1'b0;
      ST_DATA, ST_PARITY:  line_d = shift_q[0];
      default:             line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      comp_q      <= '0;
      cfg_q       <= '0;
      par_q       <= 1'b0;
      uart_tx_q   <= 1'b1;
      done_pend_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      comp_q      <= comp_d;
      cfg_q       <= cfg_d;
      par_q       <= par_d;
      // Line lags the state by one clock; tx_done is delayed to match the line.
      uart_tx_q   <= tr_en ? line_d : 1'b1;
      done_pend_q <= stop_end;
      tx_done_q   <= tr_en && done_pend_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame (FIFO_DEPTH=4, comp=3 => T=4).
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] comp = 16'd3;
  logic [1:0]  data_bits = DB_8;
  logic [1:0]  par_sel = PAR_NONE;
  logic [1:0]  stop_sel = STOP_1;
  logic        tr_en = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx_done, busy, uart_tx;
  logic [2:0]  fifo_level;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .comp       (comp),
    .data_bits  (data_bits),
    .par_sel    (par_sel),
    .stop_sel   (stop_sel),
    .tr_en      (tr_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .busy       (busy),
    .fifo_level (fifo_level),
    .uart_tx    (uart_tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  // Pushes one word into an idle transmitter and checks the whole frame.
  // slots: start, data and parity levels, one char per T=4 clock slot.
  task automatic run_frame(input string tag, input logic [7:0] w, input string slots,
                           input int stop_len);
    logic cap [0:127];
    logic dcap[0:127];
    int   len, ncap, dones;
    logic obs, e;
    len  = 4 * slots.len() + stop_len;
    ncap = len + 4;
    push(w);
    cap[0] = uart_tx; dcap[0] = tx_done;
    for (int c = 1; c < ncap; c++) begin
      @(posedge clk); #1;
      cap[c] = uart_tx; dcap[c] = tx_done;
    end
    check_eq({tag, "_latency_idle"}, 32'(cap[1]), 32'd1);
    for (int s = 0; s < slots.len(); s++) begin
      e   = (slots[s] == "1");
      obs = e;
      for (int k = 0; k < 4; k++) if (cap[2 + 4*s + k] !== e) obs = cap[2 + 4*s + k];
      check_eq($sformatf("%s_slot%0d", tag, s), 32'(obs), 32'(e));
    end
    obs = 1'b1;
    for (int k = 0; k < stop_len; k++) if (cap[2 + 4*slots.len() + k] !== 1'b1) obs = cap[2 + 4*slots.len() + k];
    check_eq({tag, "_stop"}, 32'(obs), 32'd1);
    dones = 0;
    for (int c = 0; c < ncap; c++) if (dcap[c] === 1'b1) dones++;
    check_eq({tag, "_done_count"}, 32'(dones), 32'd1);
    check_eq({tag, "_done_pos"}, 32'(dcap[2 + len]), 32'd1);
  endtask

  logic bcap [0:255];
  logic bdone[0:255];

  initial begin
    // Reset state
    #12;
    check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_done", 32'(tx_done), 32'd0);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5
    run_frame("8n1_a5", 8'hA5, "010100101", 4);

    // 7E1.5 0x35: data 1,0,1,0,1,1,0 parity 0, stop 6 clocks
    data_bits = DB_7; par_sel = PAR_EVEN; stop_sel = STOP_1P5;
    run_frame("7e15_35", 8'h35, "010101100", 6);

    // Same with odd parity
    par_sel = PAR_ODD;
    run_frame("7o15_35", 8'h35, "010101101", 6);

    // Back-to-back 0x01..0x05, 8N1
    data_bits = DB_8; par_sel = PAR_NONE; stop_sel = STOP_1;
    repeat (3) @(negedge clk);
    fork
      begin
        int wcnt;
        for (int k = 1; k <= 5; k++) begin
          tx_data  = 8'(k);
          tx_valid = 1'b1;
          wcnt = 0;
          while (!tx_ready && wcnt < 200) begin @(negedge clk); wcnt++; end
          @(posedge clk);
          @(negedge clk);
        end
        tx_valid = 1'b0;
        check_eq("b2b_full_level", 32'(fifo_level), 32'd4);
        check_eq("b2b_ready_low", 32'(tx_ready), 32'd0);
      end
      begin
        for (int c = 0; c < 206; c++) begin
          @(posedge clk); #1;
          bcap[c] = uart_tx; bdone[c] = tx_done;
        end
      end
    join
    begin
      int dones;
      logic obs, e;
      logic [7:0] w;
      for (int f = 0; f < 5; f++) begin
        w   = 8'(f + 1);
        obs = 1'b0;
        for (int j = 0; j < 40; j++) begin
          if (j < 4) e = 1'b0;
          else if (j < 36) e = w[(j - 4) / 4];
          else e = 1'b1;
          if (bcap[2 + 40*f + j] !== e) obs = 1'b1;
        end
        check_eq($sformatf("b2b_frame%0d", f), 32'(obs), 32'd0);
      end
      dones = 0;
      for (int c = 0; c < 206; c++) if (bdone[c] === 1'b1) dones++;
      check_eq("b2b_done_count", 32'(dones), 32'd5);
      check_eq("b2b_done_boundary", 32'(bdone[42]), 32'd1);
      check_eq("b2b_final_idle", 32'(bcap[204]), 32'd1);
    end

    // Abort during DATA of the first of three queued bytes
    repeat (3) @(negedge clk);
    push(8'h11); push(8'h22); push(8'h33);
    repeat (8) @(posedge clk);
    #1 check_eq("abort_busy_before", 32'(busy), 32'd1);
    @(negedge clk) tr_en = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("abort_level", 32'(fifo_level), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ready", 32'(tx_ready), 32'd0);
    @(negedge clk) tr_en = 1'b1;
    begin
      logic seen0, seen_done;
      seen0 = 1'b0; seen_done = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (uart_tx !== 1'b1) seen0 = 1'b1;
        if (tx_done !== 1'b0) seen_done = 1'b1;
      end
      check_eq("abort_line_idle", 32'(seen0), 32'd0);
      check_eq("abort_no_done", 32'(seen_done), 32'd0);
    end

    // Asynchronous reset mid-frame
    push(8'hC3); push(8'h3C);
    repeat (15) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_eq("arst_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_level", 32'(fifo_level), 32'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("post_rst_5a", 8'h5A, "001011010", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
